alarma_secuenciador: RTL and testbench

//  Alarm-level controller sitting between the raw sensor inputs (temp, humo, cor)
//  and the LED / buzzer / 7-segment outputs of the fire-alarm system.

---
 rtl/alarma_secuenciador.sv | 186 ++++++++++++++++++
 tb/tb_alarma_secuenciador.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alarma_secuenciador.sv
// Fire-alarm level sequencer: synchronises the sensor inputs, turns them into
// a requested alarm level, and walks the system state APAGADO/NORMAL/
// PREVENCION/ALERTA with persistence before escalating and hold before
// de-escalating. Drives LEDs, buzzers, the display state code and a change pulse.
module alarma_secuenciador #(
    parameter int          PRESC_W    = 17,
    parameter int          PERSIST    = 2,
    parameter int          HOLD       = 4,
    parameter logic [3:0]  COR_PREV   = 4'd8,
    parameter logic [3:0]  COR_ALERTA = 4'd14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interruptor,
    input  logic       temp,
    input  logic       humo,
    input  logic [3:0] cor,
    output logic       LEDnormal,
    output logic       LEDprevencion,
    output logic       LEDalerta,
    output logic       alarma_prevencion,
    output logic       alarma_alerta,
    output logic [1:0] estado,
    output logic       cambio
);

    typedef enum logic [1:0] {
        APAGADO    = 2'b00,
        NORMAL     = 2'b01,
        PREVENCION = 2'b10,
        ALERTA     = 2'b11
    } estado_t;

    localparam int ESC_W  = $clog2(PERSIST + 1);
    localparam int HOLD_W = $clog2(HOLD + 1);

    // Two-flop synchroniser chain for all asynchronous inputs, packed as
    // {interruptor, temp, humo, cor}.
    logic [6:0] sync1_q, sync2_q;

    logic       interruptor_s, temp_s, humo_s;
    logic [3:0] cor_s;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;

    estado_t            estado_q, estado_d, req;
    logic [ESC_W-1:0]   esc_cnt_q, esc_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic [2:0] led_q, led_d;          // {alerta, prevencion, normal}
    logic       ap_q, ap_d;
    logic       aa_q, aa_d;
    logic       cambio_q, cambio_d;

    // Synchronise the raw inputs into the clock domain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {interruptor, temp, humo, cor};
            sync2_q <= sync1_q;
        end
    end

    assign interruptor_s = sync2_q[6];
    assign temp_s        = sync2_q[5];
    assign humo_s        = sync2_q[4];
    assign cor_s         = sync2_q[3:0];

    // Prescaler: free-runs only while the system is enabled, ticks on all-ones.
    always_comb begin
        presc_d = interruptor_s ? presc_q + 1'b1 : '0;
        tick    = interruptor_s && (&presc_q);
    end

    // Requested alarm level from the synchronised sensors.
    always_comb begin
        req = NORMAL;
        if ((temp_s && humo_s) || (cor_s >= COR_ALERTA)) begin
            req = ALERTA;
        end else if (temp_s || humo_s || (cor_s >= COR_PREV)) begin
            req = PREVENCION;
        end
    end

    // Next-state logic: enable/disable, then persistence/hold filtering on ticks.
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        estado_d   = estado_q;
        esc_cnt_d  = esc_cnt_q;
        hold_cnt_d = hold_cnt_q;
        if (!interruptor_s) begin
            estado_d   = APAGADO;
            esc_cnt_d  = '0;
            hold_cnt_d = '0;
        end else if (estado_q == APAGADO) begin
            estado_d   = NORMAL;
            esc_cnt_d  = '0;
            hold_cnt_d = '0;
        end else if (tick) begin
            if (req > estado_q) begin
                hold_cnt_d = '0;
                if (esc_cnt_q == ESC_W'(PERSIST - 1)) begin
                    estado_d  = req;
                    esc_cnt_d = '0;
                end else begin
                    esc_cnt_d = esc_cnt_q + 1'b1;
                end
            end else if (req < estado_q) begin
                esc_cnt_d = '0;
                if (hold_cnt_q == HOLD_W'(HOLD - 1)) begin
                    estado_d   = req;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end else begin
                esc_cnt_d  = '0;
                hold_cnt_d = '0;
            end
        end
    end

    // Output decode from the next state so outputs register alongside estado.
    always_comb begin
        led_d    = 3'b000;
        aa_d     = 1'b0;
        ap_d     = 1'b0;
        cambio_d = (estado_d != estado_q);
        case (estado_d)
            NORMAL:     led_d = 3'b001;
            PREVENCION: led_d = 3'b010;
            ALERTA: begin
                led_d = 3'b100;
                aa_d  = 1'b1;
            end
            default:    led_d = 3'b000;
        endcase
        if (estado_d == PREVENCION) begin
            if (estado_q != PREVENCION) begin
                ap_d = 1'b1;
            end else if (tick) begin
                ap_d = ~ap_q;
            end else begin
                ap_d = ap_q;
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            estado_q   <= APAGADO;
            esc_cnt_q  <= '0;
            hold_cnt_q <= '0;
            led_q      <= '0;
            ap_q       <= 1'b0;
            aa_q       <= 1'b0;
            cambio_q   <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            estado_q   <= estado_d;
            esc_cnt_q  <= esc_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            led_q      <= led_d;
            ap_q       <= ap_d;
            aa_q       <= aa_d;
            cambio_q   <= cambio_d;
        end
    end

    assign LEDnormal         = led_q[0];
    assign LEDprevencion     = led_q[1];
    assign LEDalerta         = led_q[2];
    assign alarma_prevencion = ap_q;
    assign alarma_alerta     = aa_q;
    assign estado            = estado_q;
    assign cambio            = cambio_q;

endmodule

// File: tb/tb_alarma_secuenciador.sv
// Directed bench for alarma_secuenciador with a 16-cycle tick period.
// Cycle numbers count rising edges after reset release; inputs are driven and
// outputs sampled 1 time unit after a rising edge.
module tb_alarma_secuenciador;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       interruptor = 1'b0;
    logic       temp = 1'b0;
    logic       humo = 1'b0;
    logic [3:0] cor = 4'd0;
    logic       LEDnormal, LEDprevencion, LEDalerta;
    logic       alarma_prevencion, alarma_alerta, cambio;
    logic [1:0] estado;
    logic [7:0] outs;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int         at;
        logic       intr;
        logic       temp;
        logic       humo;
        logic [3:0] cor;
        logic [1:0] e_est;
        logic       e_ap;
        logic       e_cb;
    } vec_t;

    vec_t vecs[$];

    alarma_secuenciador #(
        .PRESC_W(4), .PERSIST(2), .HOLD(4), .COR_PREV(4'd8), .COR_ALERTA(4'd14)
    ) dut (
        .clk(clk), .rst(rst), .interruptor(interruptor), .temp(temp), .humo(humo),
        .cor(cor), .LEDnormal(LEDnormal), .LEDprevencion(LEDprevencion),
        .LEDalerta(LEDalerta), .alarma_prevencion(alarma_prevencion),
        .alarma_alerta(alarma_alerta), .estado(estado), .cambio(cambio)
    );

    always #5 clk = ~clk;

    assign outs = {estado, LEDalerta, LEDprevencion, LEDnormal,
                   alarma_alerta, alarma_prevencion, cambio};

    // Expected output vector: LEDs one-hot by state, continuous buzzer in ALERTA.
    function automatic logic [7:0] expv(input logic [1:0] est, input logic ap, input logic cb);
        logic [2:0] leds;
        case (est)
            2'd1:    leds = 3'b001;
            2'd2:    leds = 3'b010;
            2'd3:    leds = 3'b100;
            default: leds = 3'b000;
        endcase
        return {est, leds, (est == 2'd3), ap, cb};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got est/leds/aa/ap/cb=%b required %b", name, act, exp);
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic add(input int at, input logic i, input logic t, input logic h,
                       input logic [3:0] c, input logic [1:0] est, input logic ap,
                       input logic cb);
        vec_t v;
        v.at = at; v.intr = i; v.temp = t; v.humo = h; v.cor = c;
        v.e_est = est; v.e_ap = ap; v.e_cb = cb;
        vecs.push_back(v);
    endtask

    initial begin
        // Each row: at cycle 'at' compare outputs, then drive the listed inputs.
        //   at  intr t h cor  est ap cb
        add(  1, 1'b0, 0, 0, 4'd0,  2'd0, 0, 0);
        add(  4, 1'b1, 0, 0, 4'd0,  2'd0, 0, 0);  // enable
        add(  6, 1'b1, 0, 0, 4'd0,  2'd0, 0, 0);
        add(  7, 1'b1, 0, 1, 4'd0,  2'd1, 0, 1);  // NORMAL on 3rd clk; smoke on
        add(  8, 1'b1, 0, 1, 4'd0,  2'd1, 0, 0);
        add( 22, 1'b1, 0, 1, 4'd0,  2'd1, 0, 0);  // 1st tick
        add( 37, 1'b1, 0, 1, 4'd0,  2'd1, 0, 0);
        add( 38, 1'b1, 0, 1, 4'd0,  2'd2, 1, 1);  // 2nd tick -> PREVENCION
        add( 39, 1'b1, 0, 1, 4'd0,  2'd2, 1, 0);
        add( 54, 1'b1, 0, 1, 4'd0,  2'd2, 0, 0);  // buzzer toggles
        add( 70, 1'b1, 0, 0, 4'd0,  2'd2, 1, 0);  // smoke off
        add( 86, 1'b1, 0, 0, 4'd0,  2'd2, 0, 0);
        add(133, 1'b1, 0, 0, 4'd0,  2'd2, 0, 0);
        add(134, 1'b1, 1, 1, 4'd0,  2'd1, 0, 1);  // 4th lower tick -> NORMAL
        add(150, 1'b1, 1, 1, 4'd0,  2'd1, 0, 0);
        add(166, 1'b1, 0, 0, 4'd15, 2'd3, 0, 1);  // direct jump to ALERTA
        add(198, 1'b1, 0, 0, 4'd1,  2'd3, 0, 0);  // cor=15 holds ALERTA
        add(261, 1'b1, 0, 0, 4'd1,  2'd3, 0, 0);
        add(262, 1'b1, 0, 0, 4'd8,  2'd1, 0, 1);  // ALERTA -> NORMAL directly
        add(278, 1'b1, 0, 0, 4'd8,  2'd1, 0, 0);
        add(294, 1'b1, 0, 0, 4'd7,  2'd2, 1, 1);  // cor at PREV threshold
        add(357, 1'b1, 0, 0, 4'd7,  2'd2, 0, 0);
        add(358, 1'b1, 0, 0, 4'd7,  2'd1, 0, 1);
        add(390, 1'b1, 0, 0, 4'd0,  2'd1, 0, 0);  // cor=7 does not escalate
        add(399, 1'b1, 0, 1, 4'd0,  2'd1, 0, 0);  // glitch 1 straddles tick 406
        add(406, 1'b1, 0, 1, 4'd0,  2'd1, 0, 0);
        add(409, 1'b1, 0, 0, 4'd0,  2'd1, 0, 0);
        add(422, 1'b1, 0, 0, 4'd0,  2'd1, 0, 0);
        add(431, 1'b1, 0, 1, 4'd0,  2'd1, 0, 0);  // glitch 2 straddles tick 438
        add(438, 1'b1, 0, 1, 4'd0,  2'd1, 0, 0);
        add(441, 1'b1, 0, 0, 4'd0,  2'd1, 0, 0);
        add(455, 1'b1, 0, 0, 4'd14, 2'd1, 0, 0);  // glitches never accumulated
        add(470, 1'b1, 0, 0, 4'd14, 2'd1, 0, 0);
        add(486, 1'b0, 0, 0, 4'd14, 2'd3, 0, 1);  // cor at ALERTA threshold; switch off
        add(488, 1'b0, 0, 0, 4'd14, 2'd3, 0, 0);
        add(489, 1'b0, 0, 0, 4'd14, 2'd0, 0, 1);  // APAGADO on 3rd clk
        add(490, 1'b0, 0, 0, 4'd0,  2'd0, 0, 0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        check("reset_state", outs, expv(2'd0, 1'b0, 1'b0));

        for (int k = 0; k < vecs.size(); k++) begin
            run_to(vecs[k].at);
            check($sformatf("vec%0d_cyc%0d", k, vecs[k].at), outs,
                  expv(vecs[k].e_est, vecs[k].e_ap, vecs[k].e_cb));
            interruptor = vecs[k].intr;
            temp        = vecs[k].temp;
            humo        = vecs[k].humo;
            cor         = vecs[k].cor;
        end

        // Re-enable, start escalating, then async reset mid-escalation.
        run_to(496); interruptor = 1'b1;
        run_to(499); check("reenable", outs, expv(2'd1, 1'b0, 1'b1));
        humo = 1'b1;
        run_to(514); check("partial_esc", outs, expv(2'd1, 1'b0, 1'b0));
        run_to(520); rst = 1'b1;
        #1;          check("rst_async", outs, expv(2'd0, 1'b0, 1'b0));
        run_to(522); rst = 1'b0;
        run_to(525); check("after_rst_normal", outs, expv(2'd1, 1'b0, 1'b1));
        run_to(540); check("after_rst_tick1", outs, expv(2'd1, 1'b0, 1'b0));
        run_to(556); check("after_rst_tick2", outs, expv(2'd2, 1'b1, 1'b1));

        // Short off/on of the switch re-enters NORMAL with a fresh prescaler.
        run_to(560); interruptor = 1'b0;
        run_to(563); check("offon_apagado", outs, expv(2'd0, 1'b0, 1'b1));
        interruptor = 1'b1;
        run_to(566); check("offon_normal", outs, expv(2'd1, 1'b0, 1'b1));
        run_to(581); check("offon_tick1", outs, expv(2'd1, 1'b0, 1'b0));
        run_to(597); check("offon_tick2", outs, expv(2'd2, 1'b1, 1'b1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
